// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - shared types and constants for the instruction fetch path
package riscv_fetch_pkg;

  localparam int FETCH_WORD_BYTES = 4;
  localparam int FETCH_DATA_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous response FIFO with flush; head word gated to zero when empty
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the head is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_master.sv
// rtl/instr_fetch_master.sv - sequential prefetcher on the req/gnt/rvalid instruction port
// Credits (outstanding + buffered) never exceed DEPTH, so responses are always accepted.
module instr_fetch_master
  import riscv_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 34,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  output logic                  fetch_valid_o,
  output logic [31:0]           fetch_rdata_o,
  output logic [ADDR_WIDTH-1:0] fetch_addr_o,
  input  logic                  fetch_ready_i,
  output logic                  busy_o,
  output logic                  instr_req_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [31:0]           instr_rdata_i
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int OCC_W = CW + 1;

  typedef struct packed {
    logic [FETCH_DATA_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH-1:0]       addr;
  } fetch_entry_t;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, req_addr_q, push_addr_q;
  logic [ADDR_WIDTH-1:0] branch_target, load_addr;
  logic [CW-1:0]         outstanding_q, outstanding_d, discard_q, discard_d;
  logic [CW-1:0]         fifo_count, fifo_count_d;
  logic [OCC_W-1:0]      occ_next;
  logic                  pend_discard_q, granted_q;
  logic                  gnt_acc, rsp, rsp_keep, pop, load;
  logic                  fifo_full, fifo_empty;
  fetch_entry_t          push_entry, head_entry;

  assign instr_req_o   = (state_q == REQ);
  assign instr_addr_o  = req_addr_q;
  assign gnt_acc       = instr_req_o & instr_gnt_i;
  assign rsp           = instr_rvalid_i & (outstanding_q != '0);
  assign rsp_keep      = rsp & (discard_q == '0);
  assign pop           = fetch_valid_o & fetch_ready_i;
  assign branch_target = branch_addr_i & ~ADDR_WIDTH'(FETCH_WORD_BYTES - 1);
  assign busy_o        = (outstanding_q != '0) | instr_req_o;
  assign push_entry    = '{rdata: instr_rdata_i, addr: push_addr_q};

  // Occupancy is projected one cycle ahead so a request raised now is always covered by a free slot.
  always_comb begin
    outstanding_d = outstanding_q + CW'(gnt_acc) - CW'(rsp);
    fifo_count_d  = branch_i ? '0 : fifo_count + CW'(rsp_keep) - CW'(pop);
    if (branch_i) discard_d = outstanding_d;
    else          discard_d = discard_q - CW'(rsp & (discard_q != '0)) + CW'(gnt_acc & pend_discard_q);
    occ_next = OCC_W'(outstanding_d) + OCC_W'(fifo_count_d);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fetch_en_i && occ_next < OCC_W'(DEPTH)) state_d = REQ;
      REQ:     if (gnt_acc) state_d = (fetch_en_i && occ_next < OCC_W'(DEPTH)) ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
    load      = (state_d == REQ) && ((state_q == IDLE) || gnt_acc);
    load_addr = branch_i ? branch_target : next_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      next_addr_q    <= '0;
      req_addr_q     <= '0;
      push_addr_q    <= '0;
      outstanding_q  <= '0;
      discard_q      <= '0;
      pend_discard_q <= 1'b0;
      granted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      if (load) begin
        req_addr_q  <= load_addr;
        next_addr_q <= load_addr + ADDR_WIDTH'(FETCH_WORD_BYTES);
      end else if (branch_i) begin
        next_addr_q <= branch_target;
      end
      if (branch_i)      push_addr_q <= branch_target;
      else if (rsp_keep) push_addr_q <= push_addr_q + ADDR_WIDTH'(FETCH_WORD_BYTES);
      // A request still waiting for grant at a branch belongs to the old stream.
      if (branch_i && instr_req_o && !instr_gnt_i) pend_discard_q <= 1'b1;
      else if (gnt_acc)                            pend_discard_q <= 1'b0;
      if (gnt_acc) granted_q <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_keep),
    .wdata (push_entry),
    .pop   (pop),
    .flush (branch_i),
    .rdata (head_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fetch_valid_o = ~fifo_empty;
  assign fetch_rdata_o = head_entry.rdata;
  assign fetch_addr_o  = head_entry.addr;

  a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
    instr_req_o && !instr_gnt_i |=> instr_req_o && $stable(instr_addr_o));
  a_rsp_credit: assert property (@(posedge clk) disable iff (!rst_n)
    instr_rvalid_i |-> (outstanding_q != '0) || !granted_q);
  a_occupancy: assert property (@(posedge clk) disable iff (!rst_n)
    (OCC_W'(outstanding_q) + OCC_W'(fifo_count)) <= OCC_W'(DEPTH));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_keep && !branch_i && fifo_full && !pop));

endmodule
